// File: rtl/usrt_pkg.sv
// USRT transmitter shared types and constants.
// Parity support is compiled in with USRT_TX_PARITY_EN.
package usrt_pkg;

   localparam int DATA_W_MIN    = 5;
   localparam int DATA_W_MAX    = 16;
   localparam int STOP_BITS_MIN = 1;
   localparam int STOP_BITS_MAX = 2;

   localparam logic IDLE_LVL = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
`ifdef USRT_TX_PARITY_EN
      ST_PARITY = 3'd3,
`endif
      ST_STOP   = 3'd4
   } usrt_state_e;

   function automatic int clamp_i(input int v, input int lo, input int hi);
      if (v < lo) return lo;
      if (v > hi) return hi;
      return v;
   endfunction

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/usrt_baud_gen.sv
// Bit-period down-counter with half-period compare.
// Produces the bit boundary strobe and the mid-bit serial clock level.
module usrt_baud_gen #(
   parameter int DIV_W = 16
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_load,
   input  logic             i_run,
   input  logic [DIV_W-1:0] i_div,
   output logic             o_bit_end,
   output logic             o_clk_hi
);

   logic [DIV_W-1:0] div_q, div_d;
   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic [DIV_W:0]   half;

   // Latch the divider on accept, reload the counter at each bit end.
   always_comb begin
      div_d = div_q;
      cnt_d = cnt_q;
      if (i_load) begin
         div_d = i_div;
         cnt_d = i_div;
      end else if (i_run) begin
         if (cnt_q == '0) begin
            cnt_d = div_q;
         end else begin
            cnt_d = cnt_q - 1'b1;
         end
      end
   end

   // Strobes: bit end at zero count, clock high in the second half.
   always_comb begin
      half      = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
      o_bit_end = i_run && (cnt_q == '0);
      o_clk_hi  = i_run && ({1'b0, cnt_q} < half);
   end

   // Counter and divider registers.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         div_q <= '0;
         cnt_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/usrt_tx.sv
// Synchronous serial transmitter: start, LSB-first data, stop bits.
// Optional parity bit and i_Parity_Odd port with USRT_TX_PARITY_EN.
module usrt_tx
   import usrt_pkg::*;
#(
   parameter int DATA_W    = 8,
   parameter int DIV_W     = 16,
   parameter int STOP_BITS = 1
) (
   input  logic              i_Clk,
   input  logic              i_Rst_n,
   input  logic [DIV_W-1:0]  i_Div,
   input  logic              i_Valid,
   input  logic [DATA_W-1:0] i_Data,
`ifdef USRT_TX_PARITY_EN
   input  logic              i_Parity_Odd,
`endif
   output logic              o_Ready,
   output logic              o_Tx_Serial,
   output logic              o_Tx_Clk,
   output logic              o_Busy,
   output logic              o_Done
);

   localparam int STOPS = clamp_i(STOP_BITS, STOP_BITS_MIN, STOP_BITS_MAX);
   localparam int DW_OK = clamp_i(DATA_W, DATA_W_MIN, DATA_W_MAX);
   localparam int BIT_W = cnt_w(DW_OK);

   localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
   localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOPS - 1);

   usrt_state_e       state_q, state_d;
   logic [DATA_W-1:0] shreg_q, shreg_d;
   logic [BIT_W-1:0]  bit_cnt_q, bit_cnt_d;
   logic              done_q, done_d;
   logic              rdy_en_q, rdy_en_d;
`ifdef USRT_TX_PARITY_EN
   logic              par_q, par_d;
`endif

   logic accept;
   logic run;
   logic bit_end;
   logic clk_hi;

   usrt_baud_gen #(
      .DIV_W(DIV_W)
   ) u_baud (
      .i_clk    (i_Clk),
      .i_rst_n  (i_Rst_n),
      .i_load   (accept),
      .i_run    (run),
      .i_div    (i_Div),
      .o_bit_end(bit_end),
      .o_clk_hi (clk_hi)
   );

   // Handshake and status decode.
   always_comb begin
      run     = (state_q != ST_IDLE);
      o_Ready = rdy_en_q && (state_q == ST_IDLE);
      o_Busy  = run;
      o_Done  = done_q;
      accept  = i_Valid && o_Ready;
   end

   // Next-state, shift register and bit counter.
   always_comb begin
      state_d   = state_q;
      shreg_d   = shreg_q;
      bit_cnt_d = bit_cnt_q;
      done_d    = 1'b0;
      rdy_en_d  = 1'b1;
`ifdef USRT_TX_PARITY_EN
      par_d     = par_q;
`endif
      unique case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d   = ST_START;
               shreg_d   = i_Data;
               bit_cnt_d = '0;
`ifdef USRT_TX_PARITY_EN
               par_d     = (^i_Data) ^ i_Parity_Odd;
`endif
            end
         end
         ST_START: begin
            if (bit_end) begin
               state_d   = ST_DATA;
               bit_cnt_d = '0;
            end
         end
         ST_DATA: begin
            if (bit_end) begin
               shreg_d = shreg_q >> 1;
               if (bit_cnt_q == LAST_DATA) begin
                  bit_cnt_d = '0;
`ifdef USRT_TX_PARITY_EN
                  state_d   = ST_PARITY;
`else
                  state_d   = ST_STOP;
`endif
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
`ifdef USRT_TX_PARITY_EN
         ST_PARITY: begin
            if (bit_end) begin
               state_d   = ST_STOP;
               bit_cnt_d = '0;
            end
         end
`endif
         ST_STOP: begin
            if (bit_end) begin
               if (bit_cnt_q == LAST_STOP) begin
                  state_d   = ST_IDLE;
                  bit_cnt_d = '0;
                  done_d    = 1'b1;
               end else begin
                  bit_cnt_d = bit_cnt_q + BIT_W'(1);
               end
            end
         end
         default: begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
         end
      endcase
   end

   // Serial line level and bit clock per state.
   always_comb begin
      o_Tx_Serial = IDLE_LVL;
      o_Tx_Clk    = clk_hi;
      unique case (state_q)
         ST_START:  o_Tx_Serial = 1'b0;
         ST_DATA:   o_Tx_Serial = shreg_q[0];
`ifdef USRT_TX_PARITY_EN
         ST_PARITY: o_Tx_Serial = par_q;
`endif
         default:   o_Tx_Serial = IDLE_LVL;
      endcase
   end

   // Frame state registers.
   always_ff @(posedge i_Clk or negedge i_Rst_n) begin
      if (!i_Rst_n) begin
         state_q   <= ST_IDLE;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         done_q    <= 1'b0;
         rdy_en_q  <= 1'b0;
`ifdef USRT_TX_PARITY_EN
         par_q     <= 1'b0;
`endif
      end else begin
         state_q   <= state_d;
         shreg_q   <= shreg_d;
         bit_cnt_q <= bit_cnt_d;
         done_q    <= done_d;
         rdy_en_q  <= rdy_en_d;
`ifdef USRT_TX_PARITY_EN
         par_q     <= par_d;
`endif
      end
   end

endmodule

// File: tb/tb_usrt_tx.sv
// Self-checking bench for usrt_tx (one and two stop-bit instances).
// Follows USRT_TX_PARITY_EN when it is defined for the build.
module tb_usrt_tx;

`ifdef USRT_TX_PARITY_EN
   localparam int PB = 1;
`else
   localparam int PB = 0;
`endif

   logic             clk;
   logic             rst_n;
   logic [1:0]       v;
   logic [1:0][7:0]  d;
   logic [1:0][15:0] dv;
   logic [1:0]       od;
   logic [1:0]       rdy, ser, tck, bsy, dn;

   int total = 0;
   int bad   = 0;

   usrt_tx #(.DATA_W(8), .DIV_W(16), .STOP_BITS(1)) dut0 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Div(dv[0]),
      .i_Valid(v[0]), .i_Data(d[0]),
`ifdef USRT_TX_PARITY_EN
      .i_Parity_Odd(od[0]),
`endif
      .o_Ready(rdy[0]), .o_Tx_Serial(ser[0]), .o_Tx_Clk(tck[0]),
      .o_Busy(bsy[0]), .o_Done(dn[0])
   );

   usrt_tx #(.DATA_W(8), .DIV_W(16), .STOP_BITS(2)) dut1 (
      .i_Clk(clk), .i_Rst_n(rst_n), .i_Div(dv[1]),
      .i_Valid(v[1]), .i_Data(d[1]),
`ifdef USRT_TX_PARITY_EN
      .i_Parity_Odd(od[1]),
`endif
      .o_Ready(rdy[1]), .o_Tx_Serial(ser[1]), .o_Tx_Clk(tck[1]),
      .o_Busy(bsy[1]), .o_Done(dn[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   function automatic logic [4:0] obs(input int s);
      return {ser[s], tck[s], rdy[s], bsy[s], dn[s]};
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", nm, act, exp);
      end
   endtask

   // expected wire bits, LSB = first bit on the line
   function automatic logic [31:0] mk(input logic [7:0] w, input bit par,
                                      input int stops);
      logic [31:0] e;
      int p;
      e = '0;
      for (int i = 0; i < 8; i++) e[1+i] = w[i];
      p = 9;
      if (PB != 0) begin
         e[p] = par;
         p++;
      end
      for (int j = 0; j < stops; j++) e[p+j] = 1'b1;
      return e;
   endfunction

   task automatic offer(input int s, input logic [7:0] w, input int dvv,
                        input bit odd);
      int t;
      t = 0;
      @(negedge clk);
      while (!rdy[s] && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk($sformatf("ready wait s%0d", s), 32'(rdy[s]), 32'd1);
      v[s]  = 1'b1;
      d[s]  = w;
      dv[s] = dvv[15:0];
      od[s] = odd;
      @(posedge clk);
   endtask

   // Called just after the accepting edge; checks every cycle of the frame.
   task automatic frame(input int s, input logic [7:0] w, input int dvv,
                        input bit hold, input logic [7:0] nxt,
                        output logic [31:0] bits, output int nb,
                        output int done_at, output logic [14:0] trace);
      logic q[$];
      int L, H, n, stops;
      bit pb;
      logic [4:0] o;
      stops = (s == 0) ? 1 : 2;
      L  = dvv + 1;
      H  = L / 2;
      pb = (^w) ^ od[s];
      q.push_back(1'b0);
      for (int i = 0; i < 8; i++) q.push_back(w[i]);
      if (PB != 0) q.push_back(pb);
      for (int i = 0; i < stops; i++) q.push_back(1'b1);
      nb = q.size();
      bits = '0;
      done_at = -1;
      trace = '0;
      n = 0;
      for (int b = 0; b < nb; b++) begin
         for (int k = 0; k < L; k++) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
               d[s] = ~w;
               if (!hold) begin
                  v[s]  = 1'b0;
                  dv[s] = 16'($urandom);
               end
            end
            if (n == L + 1) d[s] = nxt;
            o = obs(s);
            if (o[0] && done_at < 0) done_at = n - 1;
            if (n <= 15) trace = {trace[13:0], o[3]};
            if (k == L - 1) bits[b] = o[4];
            chk($sformatf("s%0d w%02h cyc%0d", s, w, n), 32'(o),
                32'({q[b], (k >= L - H), 1'b0, 1'b1, 1'b0}));
         end
      end
      @(negedge clk);
      n++;
      o = obs(s);
      if (o[0] && done_at < 0) done_at = n - 1;
      chk($sformatf("s%0d w%02h end", s, w), 32'(o), 32'b10101);
   endtask

   typedef struct {
      int         sel;
      logic [7:0] w;
      int         dv;
      bit         odd;
      logic [7:0] nxt;
      bit         par;
      int         cyc;
   } vec_t;

   vec_t tbl[8];

   initial begin
      logic [31:0] bits;
      logic [14:0] tr;
      int nb, da, s, dvv;
      logic [7:0] w;
      bit odd;

      tbl[0] = '{0, 8'hA5, 3, 1'b0, 8'h5A, 1'b0, 4*(10+PB)};
      tbl[1] = '{0, 8'h07, 1, 1'b0, 8'h00, 1'b1, 2*(10+PB)};
      tbl[2] = '{0, 8'h07, 1, 1'b1, 8'h00, 1'b0, 2*(10+PB)};
      tbl[3] = '{0, 8'h3C, 4, 1'b0, 8'hFF, 1'b0, 5*(10+PB)};
      tbl[4] = '{0, 8'h3C, 2, 1'b0, 8'hC3, 1'b0, 3*(10+PB)};
      tbl[5] = '{1, 8'h00, 0, 1'b1, 8'h55, 1'b1, 11+PB};
      tbl[6] = '{1, 8'hFF, 2, 1'b0, 8'h00, 1'b0, 3*(11+PB)};
      tbl[7] = '{0, 8'h80, 0, 1'b0, 8'h7F, 1'b1, 10+PB};

      rst_n = 1'b0;
      v  = '0;
      d  = '0;
      dv = '0;
      od = '0;
      #1;
      chk("reset s0", 32'(obs(0)), 32'b10000);
      chk("reset s1", 32'(obs(1)), 32'b10000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      chk("release s0", 32'(obs(0)), 32'b10000);
      chk("release s1", 32'(obs(1)), 32'b10000);
      @(negedge clk);
      chk("first edge s0", 32'(obs(0)), 32'b10100);
      chk("first edge s1", 32'(obs(1)), 32'b10100);

      for (int i = 0; i < 8; i++) begin
         offer(tbl[i].sel, tbl[i].w, tbl[i].dv, tbl[i].odd);
         frame(tbl[i].sel, tbl[i].w, tbl[i].dv, 1'b0, tbl[i].nxt,
               bits, nb, da, tr);
         chk($sformatf("tbl%0d bits", i), bits,
             mk(tbl[i].w, tbl[i].par, tbl[i].sel + 1));
         chk($sformatf("tbl%0d done", i), 32'(da), 32'(tbl[i].cyc));
         if (i == 3)
            chk("tbl3 txclk", 32'(tr), 32'({3{5'b00011}}));
      end

      // back-to-back, valid held, two stop bits, one-cycle bits
      offer(1, 8'h00, 0, 1'b0);
      frame(1, 8'h00, 0, 1'b1, 8'hFF, bits, nb, da, tr);
      chk("b2b first bits", bits, mk(8'h00, 1'b0, 2));
      chk("b2b first done", 32'(da), 32'(11 + PB));
      @(posedge clk);
      frame(1, 8'hFF, 0, 1'b0, 8'h00, bits, nb, da, tr);
      chk("b2b second bits", bits, mk(8'hFF, 1'b0, 2));
      chk("b2b second done", 32'(da), 32'(11 + PB));
      @(negedge clk);
      chk("b2b after", 32'(obs(1)), 32'b10100);

      // reset during the 4th data bit
      offer(0, 8'h52, 3, 1'b0);
      for (int i = 0; i < 19; i++) begin
         @(negedge clk);
         v[0] = 1'b0;
      end
      chk("mid d3", 32'(obs(0)), 32'b01010);
      rst_n = 1'b0;
      #1;
      chk("abort now", 32'(obs(0)), 32'b10000);
      @(negedge clk);
      chk("abort held", 32'(obs(0)), 32'b10000);
      rst_n = 1'b1;
      #1;
      chk("abort release", 32'(obs(0)), 32'b10000);
      @(negedge clk);
      chk("abort ready", 32'(obs(0)), 32'b10100);
      repeat (3) begin
         @(negedge clk);
         chk("abort idle", 32'(obs(0)), 32'b10100);
      end

      // random frames against the model
      for (int r = 0; r < 30; r++) begin
         s   = $urandom_range(0, 1);
         w   = 8'($urandom);
         dvv = $urandom_range(0, 5);
         odd = 1'($urandom);
         offer(s, w, dvv, odd);
         frame(s, w, dvv, 1'b0, 8'($urandom), bits, nb, da, tr);
         chk($sformatf("rnd%0d done", r), 32'(da), 32'(nb * (dvv + 1)));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
